// File: rtl/fifo_pkg.sv
// Shared defaults and pause-FSM encoding for the destination FIFO.
// Imported by the FIFO top and its storage array.
package fifo_pkg;
  localparam int DATA_W = 6;
  localparam int DEPTH  = 8;
  localparam int PTR_W  = 3;
  localparam int UMBRAL_ALTO_DEF = 6;
  localparam int UMBRAL_BAJO_DEF = 2;

  typedef enum logic {
    LIBRE = 1'b0,
    PAUSA = 1'b1
  } estado_e;
endpackage

// File: rtl/fifo_destino_pausa_memoria.sv
// Storage array for the destination FIFO: one sync write port, one sync read port.
// Only the read register is reset; the array itself is not.
module memoria_fifo
  import fifo_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int DP = DEPTH,
  parameter int PW = PTR_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [PW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [DP];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read register holds its value when no read is performed.
  always_ff @(posedge clk) begin
    if (reset)   rdata_q <= '0;
    else if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/fifo_destino_pausa.sv
// Destination FIFO behind the routing arbiter, with hysteresis pause
// towards the arbiter pop logic and a sticky overflow/underflow flag.
module fifo_destino_pausa
  import fifo_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int DP = DEPTH,
  parameter int PW = PTR_W,
  parameter int ALTO_DEF = UMBRAL_ALTO_DEF,
  parameter int BAJO_DEF = UMBRAL_BAJO_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] data_in,
  input  logic          pop,
  input  logic          cfg_we,
  input  logic [PW:0]   cfg_alto,
  input  logic [PW:0]   cfg_bajo,
  output logic [DW-1:0] data_out,
  output logic          valid_out,
  output logic          full,
  output logic          empty,
  output logic [PW:0]   count,
  output logic          pause,
  output logic          error
);
  localparam logic [PW:0] LLENO    = (PW+1)'(DP);
  localparam logic [PW:0] ALTO_RST = (PW+1)'(ALTO_DEF);
  localparam logic [PW:0] BAJO_RST = (PW+1)'(BAJO_DEF);

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   count_q, count_d;
  logic [PW:0]   alto_q, alto_d, bajo_q, bajo_d;
  logic          valid_q, valid_d;
  logic          error_q, error_d;
  estado_e       estado_q, estado_d;
  logic          push_ok, pop_ok, ilegal;

  assign full  = (count_q == LLENO);
  assign empty = (count_q == '0);

  // A pop on a full FIFO frees the slot the push needs in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop);
  assign ilegal  = (push & full & ~pop) | (pop & empty);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop_ok)  rd_d = rd_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    valid_d = pop_ok;
    error_d = error_q | ilegal;
    alto_d  = alto_q;
    bajo_d  = bajo_q;
    if (cfg_we && (cfg_bajo < cfg_alto)) begin
      alto_d = cfg_alto;
      bajo_d = cfg_bajo;
    end
  end

  // Thresholds are compared against next-cycle occupancy.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      LIBRE:   if (count_d >= alto_q) estado_d = PAUSA;
      PAUSA:   if (count_d <= bajo_q) estado_d = LIBRE;
      default: estado_d = LIBRE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q     <= '0;
      rd_q     <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      alto_q   <= ALTO_RST;
      bajo_q   <= BAJO_RST;
      estado_q <= LIBRE;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      alto_q   <= alto_d;
      bajo_q   <= bajo_d;
      estado_q <= estado_d;
    end
  end

  memoria_fifo #(
    .DW(DW),
    .DP(DP),
    .PW(PW)
  ) u_mem (
    .clk  (clk),
    .reset(reset),
    .we   (push_ok & ~reset),
    .waddr(wr_q),
    .wdata(data_in),
    .re   (pop_ok & ~reset),
    .raddr(rd_q),
    .rdata(data_out)
  );

  assign valid_out = valid_q;
  assign count     = count_q;
  assign pause     = (estado_q == PAUSA);
  assign error     = error_q;
endmodule

// File: tb/tb_fifo_destino_pausa.sv
// Self-checking bench for fifo_destino_pausa against a queue-based model.
// Directed scenarios followed by randomized traffic.
module tb_fifo_destino_pausa;
  logic       clk = 1'b0;
  logic       reset, push, pop, cfg_we;
  logic [5:0] data_in, data_out;
  logic [3:0] cfg_alto, cfg_bajo, count;
  logic       valid_out, full, empty, pause, error;

  int checks = 0;
  int failures = 0;

  logic [5:0] q[$];
  logic [5:0] m_dout;
  bit         m_vout, m_err, m_pause;
  int         m_alto, m_bajo;

  fifo_destino_pausa dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
    .cfg_we(cfg_we), .cfg_alto(cfg_alto), .cfg_bajo(cfg_bajo),
    .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
    .count(count), .pause(pause), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, input bit pu, input logic [5:0] d,
                       input bit po, input bit cw, input int ca, input int cb);
    bit was_full, was_empty;
    if (r) begin
      q.delete();
      m_dout = '0; m_vout = 0; m_err = 0; m_pause = 0;
      m_alto = 6; m_bajo = 2;
      return;
    end
    was_full  = (q.size() == 8);
    was_empty = (q.size() == 0);
    if ((pu && was_full && !po) || (po && was_empty)) m_err = 1;
    m_vout = 0;
    if (po && !was_empty) begin
      m_dout = q.pop_front();
      m_vout = 1;
    end
    if (pu && (!was_full || po)) q.push_back(d);
    if (!m_pause && q.size() >= m_alto) m_pause = 1;
    else if (m_pause && q.size() <= m_bajo) m_pause = 0;
    if (cw && cb < ca) begin
      m_alto = ca;
      m_bajo = cb;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".count"}, int'(count), q.size());
    chk({tag, ".full"},  int'(full),  int'(q.size() == 8));
    chk({tag, ".empty"}, int'(empty), int'(q.size() == 0));
    chk({tag, ".valid"}, int'(valid_out), int'(m_vout));
    chk({tag, ".dout"},  int'(data_out),  int'(m_dout));
    chk({tag, ".pause"}, int'(pause), int'(m_pause));
    chk({tag, ".error"}, int'(error), int'(m_err));
  endtask

  task automatic step(input string tag, input bit r, input bit pu,
                      input logic [5:0] d, input bit po,
                      input bit cw = 0, input int ca = 0, input int cb = 0);
    reset = r; push = pu; data_in = d; pop = po;
    cfg_we = cw; cfg_alto = 4'(ca); cfg_bajo = 4'(cb);
    @(posedge clk);
    #1;
    model(r, pu, d, po, cw, ca, cb);
    compare_all(tag);
  endtask

  initial begin
    reset = 1; push = 0; pop = 0; data_in = '0;
    cfg_we = 0; cfg_alto = '0; cfg_bajo = '0;
    #1;

    step("rst", 1, 0, 0, 0);
    chk("rst.empty_const", int'(empty), 1);

    step("t1.push", 0, 1, 6'h15, 0);
    step("t1.push", 0, 1, 6'h2A, 0);
    step("t1.pop", 0, 0, 0, 1);
    chk("t1.d0", int'(data_out), 'h15);
    step("t1.pop", 0, 0, 0, 1);
    chk("t1.d1", int'(data_out), 'h2A);
    step("t1.idle", 0, 0, 0, 0);
    chk("t1.vdrop", int'(valid_out), 0);

    for (int i = 0; i < 8; i++) step("t2.fill", 0, 1, 6'(8'h30 + i), 0);
    chk("t2.full", int'(full), 1);
    step("t2.over", 0, 1, 6'h3F, 0);
    chk("t2.err", int'(error), 1);
    chk("t2.cnt", int'(count), 8);

    for (int i = 0; i < 6; i++) step("t3.drain", 0, 0, 0, 1);
    chk("t3.pause_off", int'(pause), 0);

    step("t4.rst", 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step("t4.fill", 0, 1, 6'(i + 1), 0);
    step("t4.pp_full", 0, 1, 6'h2E, 1);
    chk("t4.oldest", int'(data_out), 1);
    chk("t4.noerr", int'(error), 0);
    step("t4.rst2", 1, 0, 0, 0);
    step("t4.pp_empty", 0, 1, 6'h11, 1);
    chk("t4.cnt1", int'(count), 1);
    chk("t4.err1", int'(error), 1);

    step("t5.rst", 1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step("t5.push", 0, 1, 6'(i), 0);
      step("t5.pop", 0, 0, 0, 1);
      chk("t5.order", int'(data_out), i);
    end

    for (int i = 0; i < 6; i++) step("t6.fill", 0, 1, 6'(i), 0);
    step("t6.pop", 0, 0, 0, 1);
    chk("t6.p5", int'(pause), 1);
    step("t6.rst", 1, 0, 0, 0);
    chk("t6.cnt0", int'(count), 0);
    step("t6.cfg_bad", 0, 0, 0, 0, 1, 4, 5);
    for (int i = 0; i < 6; i++) step("t6.refill", 0, 1, 6'(i), 0);
    chk("t6.p6", int'(pause), 1);

    step("rnd.rst", 1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      bit r, cw;
      r  = ($urandom_range(0, 99) == 0);
      cw = ($urandom_range(0, 19) == 0);
      step("rnd", r, 1'($urandom), 6'($urandom), 1'($urandom),
           cw, int'($urandom_range(0, 8)), int'($urandom_range(0, 8)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
